// File: rtl/sap_control_sequencer.sv
// SAP-1 control unit: T-state counter, sticky halt bit and combinational instruction decode.
// Optional macro SAP_SEQ_EARLY_END_EN: return to T0 right after an instruction's last busy T-state.
module sap_control_sequencer #(
  parameter int NUM_T      = 5,
  parameter int FLAG_C_BIT = 7,
  parameter int FLAG_Z_BIT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic [7:0] flags,
  output logic [2:0] t_state,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic       f_latch,
  output logic       hlt
);

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_OUT = 4'hE, OP_HLT = 4'hF;
  localparam logic [2:0] T_LAST = 3'(NUM_T - 1);

  typedef struct packed {
    logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, out_in, f_latch, hlt;
  } ctrl_t;

  logic [2:0] t_q, t_d;
  logic       halted_q, halted_d;
  logic [3:0] op;
  logic       jmp_take;
  logic [2:0] last_exec;
  ctrl_t      ctrl, ctrl_o;

  assign op = instr[7:4];

  always_comb begin
    jmp_take = 1'b0;
    case (op)
      OP_JC:   jmp_take = flags[FLAG_C_BIT];
      OP_JZ:   jmp_take = flags[FLAG_Z_BIT];
      default: jmp_take = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_LDA, OP_STA: last_exec = 3'd3;
      OP_ADD, OP_SUB: last_exec = 3'd4;
      default:        last_exec = 3'd2;
    endcase
  end

  always_comb begin
    halted_d = halted_q;
    t_d      = t_q;
    if (halted_q) begin
      t_d = t_q;
    end else if (t_q == 3'd2 && op == OP_HLT) begin
      // Halt takes effect on the T2 edge; the counter parks at T3.
      halted_d = 1'b1;
      t_d      = 3'd3;
`ifdef SAP_SEQ_EARLY_END_EN
    end else if (t_q >= 3'd2 && t_q == last_exec) begin
      t_d = 3'd0;
`endif
    end else if (t_q == T_LAST) begin
      t_d = 3'd0;
    end else begin
      t_d = t_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q      <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl = '0;
    if (halted_q) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (t_q)
        3'd0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; end
        3'd1: begin ctrl.ram_out = 1'b1; ctrl.ir_in = 1'b1; ctrl.pc_inc = 1'b1; end
        3'd2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl.ir_out = 1'b1; ctrl.mar_in = 1'b1; end
            OP_LDI: begin ctrl.ir_out = 1'b1; ctrl.a_in = 1'b1; end
            OP_JMP: begin ctrl.ir_out = 1'b1; ctrl.pc_load = 1'b1; end
            OP_JC, OP_JZ: begin ctrl.ir_out = jmp_take; ctrl.pc_load = jmp_take; end
            OP_OUT: begin ctrl.a_out = 1'b1; ctrl.out_in = 1'b1; end
            OP_HLT: ctrl.hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (op)
            OP_LDA:         begin ctrl.ram_out = 1'b1; ctrl.a_in = 1'b1; end
            OP_ADD, OP_SUB: begin ctrl.ram_out = 1'b1; ctrl.b_in = 1'b1; end
            OP_STA:         begin ctrl.a_out = 1'b1; ctrl.ram_in = 1'b1; end
            default: ;
          endcase
        end
        3'd4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            ctrl.alu_out = 1'b1;
            ctrl.a_in    = 1'b1;
            ctrl.f_latch = 1'b1;
            ctrl.alu_sub = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces every control low even though the decode of T0 is non-empty.
  assign ctrl_o  = reset ? ctrl : '0;
  assign t_state = t_q;

  assign {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
          a_in, a_out, b_in, alu_out, alu_sub, out_in, f_latch, hlt} = ctrl_o;

  logic unused_bits;
  assign unused_bits = ^{1'b0, instr[3:0], flags, last_exec};

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: fetch/execute decode, jumps, halt and reset.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr, flags;
  logic [2:0] t_state;
  logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, alu_sub, out_in, f_latch, hlt;

  int total = 0;
  int bad   = 0;

  sap_control_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .t_state(t_state),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub),
    .out_in(out_in), .f_latch(f_latch), .hlt(hlt)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] PC_OUT = 16'h8000, PC_INC = 16'h4000, PC_LOAD = 16'h2000,
    MAR_IN = 16'h1000, RAM_OUT = 16'h0800, RAM_IN = 16'h0400, IR_IN = 16'h0200,
    IR_OUT = 16'h0100, A_IN = 16'h0080, A_OUT = 16'h0040, B_IN = 16'h0020,
    ALU_OUT = 16'h0010, ALU_SUB = 16'h0008, OUT_IN = 16'h0004, F_LATCH = 16'h0002,
    HLT = 16'h0001;
  localparam logic [15:0] F0 = PC_OUT | MAR_IN;
  localparam logic [15:0] F1 = RAM_OUT | IR_IN | PC_INC;

`ifdef SAP_SEQ_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic logic [15:0] ctrl_vec();
    return {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
            a_in, a_out, b_in, alu_out, alu_sub, out_in, f_latch, hlt};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] et, input logic [15:0] ec);
    logic [4:0] bus;
    chk({tag, ".t"}, {13'd0, t_state}, {13'd0, et});
    chk({tag, ".ctl"}, ctrl_vec(), ec);
    bus = {pc_out, ram_out, ir_out, a_out, alu_out};
    chk({tag, ".bus1hot"}, {15'd0, $countones(bus) > 1}, 16'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from T0; expects execute controls e2..e4 and a wrap after len clocks.
  task automatic run_instr(input string tag, input logic [7:0] ins, input logic [7:0] fl,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [15:0] e4, input int len);
    logic [15:0] ex [5];
    ex[0] = F0; ex[1] = F1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
    instr = ins;
    flags = fl;
    #1;
    chk_state({tag, ".T0"}, 3'd0, F0);
    for (int k = 1; k < len; k++) begin
      step();
      chk_state($sformatf("%s.T%0d", tag, k), 3'(k), ex[k]);
    end
    step();
    chk_state({tag, ".wrap"}, 3'd0, F0);
  endtask

  initial begin
    reset = 1'b0;
    instr = 8'h00;
    flags = 8'h00;
    #12;
    chk_state("rst", 3'd0, 16'h0);
    reset = 1'b1;
    #1;
    chk_state("rel", 3'd0, F0);

    run_instr("add", 8'h2A, 8'h00, IR_OUT | MAR_IN, RAM_OUT | B_IN,
              ALU_OUT | A_IN | F_LATCH, 5);
    run_instr("sub", 8'h3A, 8'h00, IR_OUT | MAR_IN, RAM_OUT | B_IN,
              ALU_OUT | A_IN | F_LATCH | ALU_SUB, 5);
    run_instr("jc_t",  8'h7C, 8'h80, IR_OUT | PC_LOAD, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("jc_nt", 8'h7C, 8'h00, 16'h0, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("jz_t",  8'h8C, 8'h40, IR_OUT | PC_LOAD, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("jz_nt", 8'h8C, 8'h80, 16'h0, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("sta", 8'h4E, 8'h00, IR_OUT | MAR_IN, A_OUT | RAM_IN, 16'h0, EARLY ? 4 : 5);
    run_instr("out", 8'hE0, 8'h00, A_OUT | OUT_IN, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("jmp", 8'h63, 8'h00, IR_OUT | PC_LOAD, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("nop", 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("ldi", 8'h55, 8'h00, IR_OUT | A_IN, 16'h0, 16'h0, EARLY ? 3 : 5);
    run_instr("lda", 8'h1E, 8'h00, IR_OUT | MAR_IN, RAM_OUT | A_IN, 16'h0, EARLY ? 4 : 5);
    run_instr("add2", 8'h2F, 8'h00, IR_OUT | MAR_IN, RAM_OUT | B_IN,
              ALU_OUT | A_IN | F_LATCH, 5);

    // Reset in the middle of an ADD (T3)
    instr = 8'h2A;
    step(); step(); step();
    chk_state("madd.T3", 3'd3, RAM_OUT | B_IN);
    reset = 1'b0;
    #1;
    chk_state("madd.rst", 3'd0, 16'h0);
    step();
    chk_state("madd.hold", 3'd0, 16'h0);
    reset = 1'b1;
    #1;
    chk_state("madd.rel", 3'd0, F0);

    // Halt parks at T3 with only hlt asserted
    instr = 8'hF0;
    step();
    chk_state("hlt.T1", 3'd1, F1);
    step();
    chk_state("hlt.T2", 3'd2, HLT);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_state("hlt.park", 3'd3, HLT);
    end
    instr = 8'h2A;
    flags = 8'hC0;
    #1;
    chk_state("hlt.newins", 3'd3, HLT);
    reset = 1'b0;
    #1;
    chk_state("hlt.rst", 3'd0, 16'h0);
    reset = 1'b1;
    #1;
    chk_state("hlt.rel", 3'd0, F0);
    step();
    chk_state("hlt.run", 3'd1, F1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control unit of the SAP-1 core: T-state counter plus instruction decode.
- Drives every bus/latch enable in the datapath, including the flags register's latch strobe.
- Consumes that register's 8-bit flag output to resolve conditional jumps.
- Sits between the instruction register (opcode source) and all datapath enables.

Parameters:
NUM_T, 5, T-states per instruction cycle (legal 5..8; T5 and above emit no controls).
FLAG_C_BIT, 7, bit index of carry within flags input.
FLAG_Z_BIT, 6, bit index of zero within flags input.

Ports:
clk  input  1  system clock (single-step/one-shot clock in the core), rising edge.
reset  input  1  asynchronous, active-low reset.
instr  input  8  instruction register contents; opcode = instr[7:4].
flags  input  8  flags register output.
t_state  output  3  current T-state index (debug/LEDs).
pc_out, pc_inc, pc_load  output  1 each  program counter bus drive / increment / load.
mar_in  output  1  memory address register load.
ram_out, ram_in  output  1 each  RAM bus drive / write.
ir_in, ir_out  output  1 each  IR load / drive operand nibble to bus.
a_in, a_out, b_in  output  1 each  A load / A bus drive / B load.
alu_out, alu_sub  output  1 each  ALU bus drive / subtract select.
out_in  output  1  output register load.
f_latch  output  1  flags register latch strobe.
hlt  output  1  halted indicator (clock gate request).

Behaviour:
- State: t counter (0..NUM_T-1) and sticky halted bit, both registered on rising clk.
- Reset low (async): t=0, halted=0. While reset is low, all control outputs are 0.
- Counter: t increments each edge and wraps NUM_T-1 -> 0. Holds while halted=1.
- Control outputs are combinational decode of (t, opcode, flags, halted).
  - They change only after a clk edge or on an instr/flags change. No registered latency beyond t.
- Halted: all controls 0 except hlt=1.
- Fetch (every opcode):
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
- Execute (T2..T4). Unlisted slots and unlisted opcodes are NOP (no controls):
  - 0 NOP: none.
  - 1 LDA: T2 ir_out, mar_in; T3 ram_out, a_in.
  - 2 ADD: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, f_latch.
  - 3 SUB: as ADD, plus alu_sub in T4.
  - 4 STA: T2 ir_out, mar_in; T3 a_out, ram_in.
  - 5 LDI: T2 ir_out, a_in.
  - 6 JMP: T2 ir_out, pc_load.
  - 7 JC: T2 ir_out and pc_load only if flags[FLAG_C_BIT]=1; else none.
  - 8 JZ: same, conditioned on flags[FLAG_Z_BIT].
  - E OUT: T2 a_out, out_in.
  - F HLT: T2 hlt=1; halted set on that edge; counter freezes at T3.
- Flag timing:
  - f_latch is asserted only in T4 of ADD/SUB; flags capture on that T4 edge.
  - A following JC/JZ samples stable flags in its own T2.
- One-hot rule: at most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is high in any state.
- Only hlt clears via reset; reset mid-instruction abandons it and restarts at T0.
- Opcode changes mid-cycle (ir_in at T1) take effect from T2 decode onward.

Optional Feature:
- Macro SAP_SEQ_EARLY_END_EN.
- Defined: after the last non-empty execute T-state, the counter returns to T0 on the next edge instead of continuing to NUM_T-1.
  - Cycle lengths: NOP and conditional jumps not taken = 3 clocks; LDI/JMP/OUT/taken jumps = 3; LDA/STA = 4; ADD/SUB = 5.
- Undefined: every instruction takes exactly NUM_T clocks.
- HLT freezes identically in both builds.

Test Plan:
- Reset low with t=3 mid-ADD -> t_state=0 and all controls 0 immediately. After release, T0 shows pc_out=1, mar_in=1.
- instr=0x2A (ADD 10) -> T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+f_latch, alu_sub=0. Wrap to T0 after NUM_T=5 clocks.
- instr=0x7C (JC 12), flags=0x80 -> T2 ir_out+pc_load. Same with flags=0x00 -> T2 all 0.
- instr=0x8C (JZ), flags=0x40 -> pc_load in T2. flags=0x80 -> no pc_load.
- instr=0xF0 (HLT) -> hlt=1 from T2. t_state stays 3 for 20 clocks, all other controls 0. Reset clears.
- SAP_SEQ_EARLY_END_EN: LDI 0x55, LDA, ADD sequence -> T0 recurs after 3, 4, 5 clocks respectively. Without macro, after 5 each.
